// File: rtl/seq_101010_detector.sv
// ---------------------------------------------------------------------------
// seq_101010_detector
//
// Purpose:
//   Mealy FSM that watches a serial bit stream, one bit per clock, and flags
//   every occurrence of the pattern 1-0-1-0-1-0. The flag is combinational
//   from the current state and the current input, so it is high during the
//   same cycle in which the final 0 is presented on x.
//
// Parameters:
//   OVERLAP : 1 = overlapping detection (the trailing "1010" of a match
//                 seeds the next match)
//             0 = non-overlapping (search restarts from scratch after a match)
//
// Ports:
//   clk   : input  1  system clock, all state updates on the rising edge
//   reset : input  1  synchronous, active-high reset (priority over x)
//   x     : input  1  serial data bit, sampled on the rising edge of clk
//   z     : output 1  detect flag, high while the sixth bit (final 0) of
//                     101010 is on x; forced low while reset is high
// ---------------------------------------------------------------------------
module seq_101010_detector #(
    parameter bit OVERLAP = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic x,
    output logic z
);

    // Each state names the longest received suffix that is also a prefix
    // of 101010.
    typedef enum logic [2:0] {
        S0 = 3'd0,  // nothing useful received
        S1 = 3'd1,  // "1"
        S2 = 3'd2,  // "10"
        S3 = 3'd3,  // "101"
        S4 = 3'd4,  // "1010"
        S5 = 3'd5   // "10101"
    } state_t;

    state_t state_q;
    state_t state_d;

    // Next-state logic. Encodings 6 and 7 are unreachable; the default arm
    // returns them to S0 on the next edge.
    always_comb begin
        state_d = S0;
        case (state_q)
            S0:      state_d = x ? S1 : S0;
            S1:      state_d = x ? S1 : S2;
            S2:      state_d = x ? S3 : S0;
            S3:      state_d = x ? S1 : S4;
            S4:      state_d = x ? S5 : S0;
            // A completed match leaves "1010" as a valid suffix; keeping it
            // is what makes detection overlapping.
            S5:      state_d = x ? S1 : (OVERLAP ? S4 : S0);
            default: state_d = S0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S0;
        end else begin
            state_q <= state_d;
        end
    end

    // Mealy output. The reset term keeps z low during reset even if the
    // register still holds S5 or x is unknown.
    always_comb begin
        z = 1'b0;
        if (!reset && (state_q == S5) && (x == 1'b0)) begin
            z = 1'b1;
        end
    end

endmodule

// File: tb/tb_seq_101010_detector.sv
// ---------------------------------------------------------------------------
// Testbench for seq_101010_detector. Two instances run side by side on the
// same stimulus: one overlapping, one non-overlapping. A shift-history
// reference model produces the expected z for each applied bit; expected
// values are queued when the bit is driven and compared mid-cycle.
// ---------------------------------------------------------------------------
module tb_seq_101010_detector;

    logic clk;
    logic reset;
    logic x;
    logic z_ov;
    logic z_no;

    int n_vec;
    int n_err;
    int pulses_ov;
    int pulses_no;

    logic exp_ov_q[$];
    logic exp_no_q[$];

    // Reference model: history of bits since the last clear, and how many
    // bits that history holds.
    logic [5:0] hist_ov;
    logic [5:0] hist_no;
    int         cnt_ov;
    int         cnt_no;

    seq_101010_detector #(.OVERLAP(1'b1)) dut_ov (
        .clk   (clk),
        .reset (reset),
        .x     (x),
        .z     (z_ov)
    );

    seq_101010_detector #(.OVERLAP(1'b0)) dut_no (
        .clk   (clk),
        .reset (reset),
        .x     (x),
        .z     (z_no)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, required normal end");
        $fatal(1, "watchdog expired");
    end

    // Drive one bit right after a rising edge, predict z from the model,
    // then compare on the falling edge (before the edge that samples x).
    task automatic apply(input logic rst, input logic xv, input string tag);
        logic e_ov;
        logic e_no;
        logic got_ov;
        logic got_no;
        @(posedge clk);
        #1;
        reset = rst;
        x     = xv;
        if (rst) begin
            e_ov = 1'b0;
            e_no = 1'b0;
            hist_ov = '0;
            hist_no = '0;
            cnt_ov  = 0;
            cnt_no  = 0;
        end else begin
            hist_ov = {hist_ov[4:0], xv};
            hist_no = {hist_no[4:0], xv};
            cnt_ov++;
            cnt_no++;
            e_ov = (cnt_ov >= 6) && (hist_ov == 6'b101010);
            e_no = (cnt_no >= 6) && (hist_no == 6'b101010);
            if (e_no) begin
                cnt_no = 0;
            end
        end
        exp_ov_q.push_back(e_ov);
        exp_no_q.push_back(e_no);
        @(negedge clk);
        got_ov = z_ov;
        got_no = z_no;
        if (got_ov === 1'b1) pulses_ov++;
        if (got_no === 1'b1) pulses_no++;
        e_ov = exp_ov_q.pop_front();
        e_no = exp_no_q.pop_front();
        n_vec++;
        if (got_ov !== e_ov) begin
            n_err++;
            $display("FAIL %s z(overlap): got %b expected %b", tag, got_ov, e_ov);
        end
        n_vec++;
        if (got_no !== e_no) begin
            n_err++;
            $display("FAIL %s z(non_overlap): got %b expected %b", tag, got_no, e_no);
        end
    endtask

    task automatic apply_bits(input logic [31:0] bits, input int len, input string tag);
        for (int i = len - 1; i >= 0; i--) begin
            apply(1'b0, bits[i], tag);
        end
    endtask

    task automatic test_reset;
        apply(1'b1, 1'bx, "reset_hold_x0");
        apply(1'b1, 1'bx, "reset_hold_x1");
        apply(1'b1, 1'b1, "reset_hold_one");
        // Released into S0: a lone 0 and 1 must not flag.
        apply(1'b0, 1'b0, "post_reset_0");
        apply(1'b0, 1'b1, "post_reset_1");
    endtask

    task automatic test_basic_match;
        apply(1'b1, 1'b0, "basic_rst");
        apply_bits(32'b101010, 6, "basic_match");
    endtask

    task automatic test_streams;
        apply(1'b1, 1'b0, "stream_rst");
        pulses_ov = 0;
        pulses_no = 0;
        apply_bits(32'b1010101010100000, 16, "stream16");
        n_vec++;
        if (pulses_ov !== 4) begin
            n_err++;
            $display("FAIL stream16_pulses_overlap: got %0d expected 4", pulses_ov);
        end
        n_vec++;
        if (pulses_no !== 2) begin
            n_err++;
            $display("FAIL stream16_pulses_non_overlap: got %0d expected 2", pulses_no);
        end
    endtask

    task automatic test_near_miss;
        apply(1'b1, 1'b0, "nm_rst_a");
        pulses_ov = 0;
        apply_bits(32'b101011, 6, "near_miss_101011");
        n_vec++;
        if (pulses_ov !== 0) begin
            n_err++;
            $display("FAIL near_miss_101011_pulses: got %0d expected 0", pulses_ov);
        end
        apply(1'b1, 1'b0, "nm_rst_b");
        pulses_ov = 0;
        apply_bits(32'b1101010, 7, "near_miss_1101010");
        n_vec++;
        if (pulses_ov !== 1) begin
            n_err++;
            $display("FAIL near_miss_1101010_pulses: got %0d expected 1", pulses_ov);
        end
        apply(1'b1, 1'b0, "nm_rst_c");
        pulses_no = 0;
        apply_bits(32'b100101010, 9, "near_miss_100101010");
        n_vec++;
        if (pulses_no !== 1) begin
            n_err++;
            $display("FAIL near_miss_100101010_pulses: got %0d expected 1", pulses_no);
        end
    endtask

    task automatic test_mid_reset;
        apply(1'b1, 1'b0, "mid_rst_init");
        apply_bits(32'b10101, 5, "mid_prefix");
        // State is S5 here; reset with x=0 must hold z low.
        apply(1'b1, 1'b0, "mid_reset_pulse");
        apply(1'b0, 1'b0, "mid_after_reset");
        apply_bits(32'b101010, 6, "mid_rematch");
    endtask

    task automatic test_random;
        apply(1'b1, 1'b0, "rand_rst");
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                apply(1'b1, 1'($urandom_range(0, 1)), "rand_reset");
            end else if ($urandom_range(0, 3) != 0) begin
                // Bias towards alternating bits so matches are frequent.
                apply(1'b0, ~hist_ov[0], "rand_alt");
            end else begin
                apply(1'b0, 1'($urandom_range(0, 1)), "rand_bit");
            end
        end
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        pulses_ov = 0;
        pulses_no = 0;
        hist_ov   = '0;
        hist_no   = '0;
        cnt_ov    = 0;
        cnt_no    = 0;
        reset     = 1'b1;
        x         = 1'b0;

        test_reset();
        test_basic_match();
        test_streams();
        test_near_miss();
        test_mid_reset();
        test_random();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/seq_101010_detector.md
Name: seq_101010_detector

Overview:
Mealy finite-state machine that monitors a 1-bit serial input, one bit per clock, and flags each occurrence of the pattern 1-0-1-0-1-0. The output is combinational from the current state and input, so the flag is asserted in the same cycle the final 0 is presented. It is used as a standalone serial-pattern detector block.

Parameters:
OVERLAP, 1, 1 = overlapping detection (a match's trailing 1010 seeds the next match); 0 = non-overlapping (search restarts after each match)

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
x  input  1  serial data bit, sampled on rising edge of clk
z  output  1  detect flag; high for the one cycle in which the sixth bit (final 0) of 101010 is on x

Behaviour:
- Clocking/reset: one clock, clk. Reset is synchronous and active-high. A rising edge with reset=1 forces state to S0. Reset has priority over x.
- While reset=1, z=0 regardless of state or x, including x=X.
- States encode the longest received suffix that is a prefix of 101010:
  - S0: none
  - S1: "1"
  - S2: "10"
  - S3: "101"
  - S4: "1010"
  - S5: "10101"
- Transitions (x=0 / x=1):
  - S0 -> S0 / S1
  - S1 -> S2 / S1
  - S2 -> S0 / S3
  - S3 -> S4 / S1
  - S4 -> S0 / S5
  - S5 -> (S4 if OVERLAP=1, else S0) / S1
- Output (Mealy): z = 1 iff state==S5 and x==0 and reset==0; otherwise z=0.
- Latency: zero cycles from the sixth bit to z. z is valid combinationally before the sampling edge of that bit.
- z has no glitch-free or registered guarantee; downstream logic samples it on clk.
- Reset mid-sequence: partial progress is discarded. The next match needs a full six new bits after reset deasserts.
- X on x outside reset: no requirement. States must be a complete case with a default to S0.
- State register encoding is implementation-defined (binary or one-hot). Unreachable encodings return to S0 on the next edge.

Test Plan:
- Reset hold: reset=1 for 2 cycles with x=X, then x=1 -> z=0 throughout reset; state S0 after.
- Basic match: after reset, x=1,0,1,0,1,0 on consecutive cycles -> z=0 on bits 1–5, z=1 only during bit 6.
- Overlap stream (OVERLAP=1): after reset, 16 bits 1010101010100000 one per cycle -> z=1 during bits 6, 8, 10, 12 (4 pulses), z=0 on all other bits.
- Non-overlap stream (OVERLAP=0): same 16-bit stream -> z=1 during bits 6 and 12 only.
- Near-miss:
  - 101011 -> z never 1.
  - 1101010 -> z=1 on bit 7 (S1 self-loop on repeated 1).
  - 100101010 -> z=1 on bit 9 (S2 reset on 0).
- Mid-sequence reset: x=1,0,1,0,1, then reset=1 for one cycle, then x=0 -> z=0. A further 101010 -> z=1 on its sixth bit.
